// File: rtl/seven_seg_disp_ctrl.sv
// Multi-digit seven-segment controller: valid/ready load, hex or double-dabble decimal, LZ blanking, overflow dashes.
// Optional per-digit blinking with macro SEVEN_SEG_BLINK_EN; all digits stay blank until the first completed load.
module seven_seg_disp_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int DATA_W     = 20,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                    MAX10_CLK1_50,
   input  logic                    reset_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [DATA_W-1:0]       value,
   input  logic                    dec_mode,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [7*NUM_DIGITS-1:0] hex,
   output logic                    overflow
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t                  state_q, state_d;
   logic                    ready_q, ready_d;
   logic [DATA_W-1:0]       val_q, val_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    cflag_q, cflag_d;
   logic                    dec_q, dec_d;
   logic [BCD_W-1:0]        disp_q, disp_d;
   logic                    dovf_q, dovf_d;
   logic                    dvld_q, dvld_d;
   logic                    ovf_q, ovf_d;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   blink_on;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      logic                      accept;
      logic [BCD_W-1:0]          adj;
      logic [BCD_W:0]            sh;
      logic [BCD_W+DATA_W-1:0]   ext;
      state_d = state_q;
      ready_d = 1'b0;
      val_d   = val_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      cflag_d = cflag_q;
      dec_d   = dec_q;
      disp_d  = disp_q;
      dovf_d  = dovf_q;
      dvld_d  = dvld_q;
      adj     = '0;
      sh      = '0;
      ext     = {{BCD_W{1'b0}}, value};
      accept  = load_valid && ready_q;
      case (state_q)
         IDLE: begin
            ready_d = !accept;
            if (accept) begin
               dec_d = dec_mode;
               if (dec_mode) begin
                  val_d   = value;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  cflag_d = 1'b0;
                  state_d = CONV;
               end else begin
                  bcd_d   = ext[BCD_W-1:0];
                  state_d = LATCH;
               end
            end
         end
         CONV: begin
            // Add-3 on digits >= 5, then shift the next value bit in; a carry out of the top digit is overflow.
            for (int i = 0; i < NUM_DIGITS; i++) begin
               adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
            end
            sh      = {adj, val_q[DATA_W-1]};
            bcd_d   = sh[BCD_W-1:0];
            cflag_d = cflag_q | sh[BCD_W];
            val_d   = val_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = LATCH;
         end
         LATCH: begin
            disp_d  = bcd_q;
            dovf_d  = dec_q & cflag_q;
            dvld_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SEVEN_SEG_BLINK_EN
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      phase_d     = phase_q;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign blink_on = blink_mask & {NUM_DIGITS{phase_q}};
`else
   logic blink_mask_unused;
   assign blink_mask_unused = ^blink_mask;
   assign blink_on          = '0;
`endif

   always_comb begin
      logic       nz;
      logic [6:0] g;
      nz    = 1'b0;
      g     = SEG_BLANK;
      hex_d = '0;
      ovf_d = dovf_q;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz = nz | (disp_q[4*i +: 4] != 4'd0);
         g  = seg7(disp_q[4*i +: 4]);
         if (dovf_q) g = SEG_DASH;
         else if (blank_lz && !nz && i != 0) g = SEG_BLANK;
         if (!dvld_q || blink_on[i]) g = SEG_BLANK;
         hex_d[7*i +: 7] = g;
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         disp_q  <= '0;
         dovf_q  <= 1'b0;
         dvld_q  <= 1'b0;
         ovf_q   <= 1'b0;
         hex_q   <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         disp_q  <= disp_d;
         dovf_q  <= dovf_d;
         dvld_q  <= dvld_d;
         ovf_q   <= ovf_d;
         hex_q   <= hex_d;
      end
   end

   // Conversion datapath needs no reset: every load reinitialises it before use.
   always_ff @(posedge MAX10_CLK1_50) begin
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      cflag_q <= cflag_d;
      dec_q   <= dec_d;
   end

   assign load_ready = ready_q;
   assign hex        = hex_q;
   assign overflow   = ovf_q;

endmodule

// File: doc/seven_seg_disp_ctrl.md
# seven_seg_disp_ctrl

Parametrised, registered multi-digit seven-segment display controller for the DE10 HEX displays. Accepts a binary value through a valid/ready load handshake and renders it as hexadecimal or decimal; decimal uses an iterative shift-add-3 (double-dabble) converter. Adds leading-zero blanking, decimal overflow indication and per-digit blinking. Sits between board-level logic (switches, counters) and the HEX0..HEXn pins.

## Interface
Parameters:
- NUM_DIGITS, 6, number of seven-segment digits driven (1..8).
- DATA_W, 20, width of the input value (1..32).
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (0.5 s at 50 MHz); minimum 2.

Ports:
- MAX10_CLK1_50  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  request to load a new value.
- load_ready  out  1  controller idle; load is accepted when load_valid && load_ready.
- value  in  DATA_W  binary value, sampled on accept.
- dec_mode  in  1  sampled on accept: 0 = hex, 1 = decimal.
- blank_lz  in  1  live: blank leading zero digits.
- blink_mask  in  NUM_DIGITS  live: bit i = digit i blinks.
- hex  out  7*NUM_DIGITS  active-low segments; digit i at [7*i+6:7*i], bit 0 = a ... bit 6 = g.
- overflow  out  1  last decimal load exceeded 10^NUM_DIGITS - 1.

## Operation
- FSM: IDLE -> (accept, dec_mode=0) -> LATCH -> IDLE; IDLE -> (accept, dec_mode=1) -> CONV -> LATCH -> IDLE.
- IDLE: load_ready=1. All other states: load_ready=0; load_valid ignored, not queued.
- Hex mode: digit i = value[4i+3:4i], zero-extended beyond DATA_W; bits of value above 4*NUM_DIGITS discarded; overflow cleared.
- CONV: exactly DATA_W cycles; each cycle adds 3 to every BCD digit >= 5, then shifts in one value bit, MSB first. Any 1 shifted out of the top BCD digit sets a sticky conversion-overflow flag.
- LATCH: copies the digit register to the display digit register; overflow <= conversion flag (decimal) or 0 (hex).
- Overflow display: all digits show dash (segment g only, 7'b0111111), regardless of blank_lz; blink still applies.
- Glyphs: 0-9, A, b, C, d, E, F standard; blank = 7'h7F.
- Leading-zero blanking (blank_lz=1): digit i (i >= 1) blanked when it and all higher digits are 0; digit 0 always shown.
- Blink: free-running counter 0..BLINK_DIV-1 toggles phase at wrap; digit i blanked while phase=1 and blink_mask[i]=1.
- Output register re-evaluates every cycle from display digits, blank_lz, blink_mask, phase, overflow.

## Timing
- Reset values: hex = all 7'h7F, load_ready = 1, overflow = 0, display digits = 0, FSM = IDLE, blink counter = 0, phase = 0.
- Accept at edge N. Hex mode: LATCH in cycle N+1, hex updated at edge N+2, load_ready high again after edge N+2.
- Decimal mode: CONV cycles N+1..N+DATA_W, LATCH in N+DATA_W+1, hex/overflow updated at edge N+DATA_W+2.
- blank_lz / blink_mask changes visible on hex one edge later.
- Reset asserted mid-CONV: conversion aborted, all reset values immediately (asynchronous); previous display lost.
- Load accepted in same cycle as blink wrap: both take effect independently.
- value = 0, blank_lz = 1: only digit 0 shows "0".

## Configuration
- SEVEN_SEG_BLINK_EN defined: blink counter, phase and blink_mask gating present as above.
- Not defined: no counter/phase logic; blink_mask port exists but is ignored; digits never blink.

## Test plan
- Reset: hold reset_n=0 -> hex all 7'h7F, load_ready=1, overflow=0; release, no load -> unchanged.
- Hex: value=20'hABCDE, dec_mode=0, blank_lz=0 -> after 2 edges digits (5..0) = 0,A,b,C,d,E; overflow=0; load_ready low exactly 2 cycles.
- Decimal with LZB: value=1234, dec_mode=1, blank_lz=1 -> after 22 edges digits 5,4 blank, digits 3..0 = 1,2,3,4; load_valid pulses during CONV ignored.
- Overflow: value=1_000_000, dec_mode=1 -> all six digits dash, overflow=1; following load of 999999 -> 9,9,9,9,9,9, overflow=0.
- Blink (macro defined, BLINK_DIV=4): blink_mask=6'b000001, value=5 hex -> digit 0 alternates "5"/blank every 4 cycles, others steady; macro undefined -> digit 0 steady.
- Reset mid-CONV: assert reset_n=0 at cycle N+10 of decimal load -> hex all 7'h7F and load_ready=1 immediately; new load after release completes normally.
